// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: sizes, FSM encoding
// and the debug command byte that requests a dump.
package regfile_dump_reader_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int BYTES_W  = DATA_W / 8;
  localparam int BCNT_W   = 2;

  // Debug-unit command byte ('D') that the command decoder turns into a Start pulse.
  localparam logic [7:0] DUMP_CMD = 8'h44;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_LOAD = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks every register through the debug read port and streams each word as
// four bytes, MSB first, to the UART TX byte interface.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_dbg_read_register,
  input  logic [DATA_W-1:0] i_dbg_read_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done,
  output dump_state_t       o_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_W - 1);

  dump_state_t       r_state;
  dump_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_index;
  logic [BCNT_W-1:0] r_byte_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              w_accept;
  logic              w_last_byte;

  // Handshake: a byte moves when o_tx_valid && i_tx_ready at posedge. o_tx_valid
  // and o_tx_data depend only on registered state, so a stalled byte holds
  // steady and valid never drops before acceptance (except on reset).
  assign w_accept    = (r_state == DUMP_SEND) && i_tx_ready;
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= DUMP_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DUMP_IDLE: if (i_start) w_state_nxt = DUMP_LOAD;
      DUMP_LOAD: w_state_nxt = DUMP_SEND;
      DUMP_SEND: begin
        if (w_accept && w_last_byte) begin
          w_state_nxt = (r_index == LAST_IDX) ? DUMP_DONE : DUMP_LOAD;
        end
      end
      DUMP_DONE: w_state_nxt = DUMP_IDLE;
      default:   w_state_nxt = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_index    <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else begin
      case (r_state)
        DUMP_IDLE: if (i_start) r_index <= '0;
        DUMP_LOAD: begin
          r_shift    <= i_dbg_read_data;
          r_byte_cnt <= '0;
        end
        DUMP_SEND: begin
          if (w_accept) begin
            r_shift <= {r_shift[DATA_W-9:0], 8'h00};
            // The counter parks at the last byte; only LOAD clears it.
            if (!w_last_byte) begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end else if (r_index != LAST_IDX) begin
              r_index <= r_index + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_dbg_read_register = '0;
    o_tx_data           = 8'h00;
    o_tx_valid          = 1'b0;
    o_busy              = (r_state != DUMP_IDLE);
    o_done              = (r_state == DUMP_DONE);
    o_state             = r_state;
    if (r_state == DUMP_LOAD || r_state == DUMP_SEND) begin
      o_dbg_read_register = r_index;
    end
    if (r_state == DUMP_SEND) begin
      o_tx_valid = 1'b1;
      o_tx_data  = r_shift[DATA_W-1 -: 8];
    end
  end

endmodule
